pe_result_accum: RTL and testbench



---
 rtl/pe_result_accum.sv | 98 +++++++++
 tb/tb_pe_result_accum.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_result_accum.sv
// K-dimension reducer behind the 2x2 systolic PE wrapper: pops partial-product
// elements from the PE output FIFO, sums num_k tiles per lane, presents the result tile.
module pe_result_accum #(
  parameter int WIDTH  = 4,
  parameter int ACC_W  = 12,
  parameter int KCNT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [KCNT_W-1:0]          num_k,
  input  logic [4*(2*WIDTH+1)-1:0]   pe_dout,
  input  logic                       pe_dout_val,
  output logic                       pe_pop,
  output logic [4*ACC_W-1:0]         res,
  output logic                       res_val,
  input  logic                       res_rdy,
  output logic                       ovf,
  output logic                       busy
);

  localparam int EW = 2*WIDTH+1;

  // Handshake: res is transferred on a cycle where res_val && res_rdy are both
  // high; res_val never drops and res never changes until that cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          elem_q;
  logic [KCNT_W-1:0]   tile_q;
  logic [KCNT_W-1:0]   nk_q;
  logic [ACC_W-1:0]    acc_q [4];
  logic                ovf_q;

  logic [EW-1:0]       din;
  logic [ACC_W:0]      sum;
  logic                last_pop;
  logic                unused_lanes;

  assign din          = pe_dout[EW-1:0];
  assign unused_lanes = ^pe_dout[4*EW-1:EW];

  assign pe_pop   = (state_q == COLLECT) && pe_dout_val;
  assign sum      = {1'b0, acc_q[elem_q]} + (ACC_W+1)'(din);
  assign last_pop = pe_pop && (elem_q == 2'd3) && (tile_q == nk_q - KCNT_W'(1));

  assign res     = {acc_q[3], acc_q[2], acc_q[1], acc_q[0]};
  assign res_val = (state_q == HOLD);
  assign busy    = (state_q != IDLE);
  assign ovf     = ovf_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = COLLECT;
      COLLECT: if (last_pop) state_d = HOLD;
      HOLD:    if (res_rdy)  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      elem_q  <= 2'd0;
      tile_q  <= '0;
      nk_q    <= KCNT_W'(1);
      ovf_q   <= 1'b0;
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        nk_q   <= (num_k == '0) ? KCNT_W'(1) : num_k;
        ovf_q  <= 1'b0;
        elem_q <= 2'd0;
        tile_q <= '0;
      end
      if (pe_pop) begin
        elem_q <= elem_q + 2'd1;
        if (elem_q == 2'd3) tile_q <= tile_q + KCNT_W'(1);
        // First tile overwrites so stale sums from the previous result never leak in.
        if (tile_q == '0) begin
          acc_q[elem_q] <= ACC_W'(din);
        end else if (sum[ACC_W]) begin
          acc_q[elem_q] <= '1;
          ovf_q         <= 1'b1;
        end else begin
          acc_q[elem_q] <= sum[ACC_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_result_accum.sv
// Bench for pe_result_accum: a FIFO model feeds elements, a plain-arithmetic model
// predicts each result tile into exp_q, and a monitor checks every accepted result.
module tb_pe_result_accum;

  localparam int WIDTH  = 4;
  localparam int ACC_W  = 12;
  localparam int KCNT_W = 4;
  localparam int EW     = 2*WIDTH+1;
  localparam int MAXV   = (1 << ACC_W) - 1;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [KCNT_W-1:0]     num_k;
  logic [4*EW-1:0]       pe_dout;
  logic                  pe_dout_val;
  logic                  pe_pop;
  logic [4*ACC_W-1:0]    res;
  logic                  res_val;
  logic                  res_rdy;
  logic                  ovf;
  logic                  busy;

  pe_result_accum #(.WIDTH(WIDTH), .ACC_W(ACC_W), .KCNT_W(KCNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_k(num_k),
    .pe_dout(pe_dout), .pe_dout_val(pe_dout_val), .pe_pop(pe_pop),
    .res(res), .res_val(res_val), .res_rdy(res_rdy), .ovf(ovf), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [EW-1:0]      fifo_q[$];
  logic [4*ACC_W:0]   exp_q[$];
  int                 dir_tab[16][4];
  int                 pop_total = 0;
  int                 gap_fixed = 0;
  int                 gap_cnt   = 0;
  bit                 gap_rand  = 0;
  bit                 rdy_rand  = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] expv);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // One clock of the FIFO model and input drivers; returns at posedge + 1.
  task automatic tick();
    logic pop_s;
    @(negedge clk);
    pop_s = pe_pop;
    if (pop_s && fifo_q.size() == 0) check(1'b0, "pop_empty", 64'(pop_s), 64'd0);
    @(posedge clk);
    #1;
    if (pop_s && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pop_total++;
      if (gap_fixed > 0) gap_cnt = gap_fixed;
    end
    if (rdy_rand) res_rdy = 1'($urandom_range(0, 1));
    if (gap_cnt > 0) begin
      pe_dout_val = 1'b0;
      gap_cnt--;
    end else begin
      pe_dout_val = (fifo_q.size() > 0) && (!gap_rand || $urandom_range(0, 3) != 0);
    end
    pe_dout = {27'($urandom), (fifo_q.size() > 0) ? fifo_q[0] : EW'($urandom)};
  endtask

  // Reference model: per-lane total over all tiles, clipped to the accumulator range.
  task automatic add_job(input int k, input int mode);
    int eff, v;
    int tot[4];
    logic [4*ACC_W:0] e;
    eff = (k == 0) ? 1 : k;
    for (int l = 0; l < 4; l++) tot[l] = 0;
    for (int t = 0; t < eff; t++) begin
      for (int l = 0; l < 4; l++) begin
        case (mode)
          1:       v = int'($urandom_range(400, 511));
          2:       v = 500;
          3:       v = dir_tab[t][l];
          default: v = int'($urandom_range(0, 255));
        endcase
        fifo_q.push_back(EW'(v));
        tot[l] += v;
      end
    end
    e = '0;
    for (int l = 0; l < 4; l++) begin
      if (tot[l] > MAXV) begin
        e[l*ACC_W +: ACC_W] = ACC_W'(MAXV);
        e[4*ACC_W] = 1'b1;
      end else begin
        e[l*ACC_W +: ACC_W] = ACC_W'(tot[l]);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input int k);
    num_k = KCNT_W'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      tick();
    end
    if (i == budget) check(1'b0, "timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_res_val(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (res_val) break;
      tick();
    end
    if (i == budget) check(1'b0, "res_val_timeout", 64'(res_val), 64'd1);
  endtask

  // scoreboard monitor
  logic rv_prev  = 1'b0;
  logic pop_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      rv_prev  = 1'b0;
      pop_prev = 1'b0;
    end else begin
      if (res_val && !rv_prev) check(pop_prev, "latency", 64'(pop_prev), 64'd1);
      if (res_val && res_rdy) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_result", 64'(res), 64'd0);
        end else begin
          logic [4*ACC_W:0] e;
          e = exp_q.pop_front();
          check({ovf, res} == e, "result", 64'({ovf, res}), 64'(e));
        end
      end
      rv_prev  = res_val;
      pop_prev = pe_pop;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got %0d expected %0d", n_checks, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin
    int base;
    rst_n = 1'b0; start = 1'b0; num_k = '0; pe_dout = '0; pe_dout_val = 1'b0; res_rdy = 1'b0;
    repeat (3) tick();
    check(res == '0 && res_val == 1'b0, "reset_res", 64'(res), 64'd0);
    check(ovf == 1'b0 && busy == 1'b0, "reset_flags", 64'({ovf, busy}), 64'd0);
    rst_n = 1'b1;
    tick();
    check(pe_pop == 1'b0 && busy == 1'b0, "post_reset_idle", 64'({pe_pop, busy}), 64'd0);

    // single tile
    res_rdy = 1'b1;
    dir_tab[0] = '{5, 6, 7, 8};
    base = pop_total;
    add_job(1, 3);
    pulse_start(1);
    wait_done(100);
    check(pop_total - base == 4, "single_pops", 64'(pop_total - base), 64'd4);

    // three tiles with 2-cycle gaps
    dir_tab[0] = '{1, 2, 3, 4};
    dir_tab[1] = '{10, 20, 30, 40};
    dir_tab[2] = '{100, 100, 100, 100};
    gap_fixed = 2;
    base = pop_total;
    add_job(3, 3);
    pulse_start(3);
    wait_done(200);
    check(pop_total - base == 12, "three_pops", 64'(pop_total - base), 64'd12);
    gap_fixed = 0;

    // backpressure with a second tile queued behind
    res_rdy = 1'b0;
    add_job(1, 0);
    add_job(1, 0);
    pulse_start(1);
    wait_res_val(100);
    for (int i = 0; i < 10; i++) begin
      check(res_val == 1'b1, "hold_val", 64'(res_val), 64'd1);
      check(pe_pop == 1'b0, "hold_no_pop", 64'(pe_pop), 64'd0);
      check(exp_q.size() > 0 && res == exp_q[0][4*ACC_W-1:0], "hold_res", 64'(res),
            64'(exp_q[0][4*ACC_W-1:0]));
      num_k = KCNT_W'(2);
      start = (i % 3 == 0);
      tick();
    end
    start = 1'b1;
    res_rdy = 1'b1;
    tick();
    start = 1'b0;
    check(busy == 1'b0, "hs_start_ignored", 64'(busy), 64'd0);
    tick();
    check(busy == 1'b0 && pe_pop == 1'b0, "idle_after_hs", 64'({busy, pe_pop}), 64'd0);
    base = pop_total;
    pulse_start(1);
    wait_done(100);
    check(pop_total - base == 4, "waiting_tile_pops", 64'(pop_total - base), 64'd4);

    // saturation, then ovf cleared by the next start
    add_job(9, 2);
    pulse_start(9);
    wait_done(300);
    add_job(1, 0);
    pulse_start(1);
    wait_done(100);

    // idle data stays in the FIFO; num_k=0 acts as 1
    base = pop_total;
    add_job(0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check(pe_pop == 1'b0 && busy == 1'b0, "idle_no_pop", 64'({pe_pop, busy}), 64'd0);
    end
    pulse_start(0);
    wait_done(100);
    check(pop_total - base == 4, "numk0_pops", 64'(pop_total - base), 64'd4);

    // async reset mid-collect
    base = pop_total;
    add_job(1, 0);
    pulse_start(1);
    for (int i = 0; i < 50; i++) begin
      if (pop_total - base >= 2) break;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check(busy == 1'b0 && res_val == 1'b0 && ovf == 1'b0, "arst_flags",
          64'({busy, res_val, ovf}), 64'd0);
    check(res == '0, "arst_res", 64'(res), 64'd0);
    void'(exp_q.pop_back());
    for (int i = 0; i < 3; i++) begin
      check(pe_pop == 1'b0, "arst_no_pop", 64'(pe_pop), 64'd0);
      tick();
    end
    fifo_q.delete();
    rst_n = 1'b1;
    tick();
    dir_tab[0] = '{9, 10, 11, 12};
    dir_tab[1] = '{1, 1, 1, 1};
    add_job(2, 3);
    pulse_start(2);
    wait_done(100);

    // randomized jobs with random gaps and backpressure
    gap_rand = 1;
    rdy_rand = 1;
    for (int j = 0; j < 20; j++) begin
      int mode, k;
      mode = ($urandom_range(0, 4) == 0) ? 1 : 0;
      k = (mode == 1) ? int'($urandom_range(8, 12)) : int'($urandom_range(0, 5));
      base = pop_total;
      add_job(k, mode);
      pulse_start(k);
      wait_done(500);
      check(pop_total - base == 4 * ((k == 0) ? 1 : k), "rand_pops", 64'(pop_total - base),
            64'(4 * ((k == 0) ? 1 : k)));
    end
    rdy_rand = 0;
    res_rdy = 1'b1;
    repeat (3) tick();
    check(exp_q.size() == 0, "exp_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
